// File: rtl/alu_srcb_stage.sv
// -----------------------------------------------------------------------------
// alu_srcb_stage
//
// Registered operand-B stage for the multicycle datapath ALU. It selects one of
// six operand sources (B register, increment constant, sign/zero-extended
// immediate, word-offset immediate, upper immediate). The result is held in a
// main output register backed by a one-entry skid register, so the ALU can
// stall without losing operands.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high. A producer holds valid and its payload stable
// until that edge. in_ready is driven straight from a flop. out_valid,
// srcb_out and out_illegal come only from flops. No combinational path
// exists from any input to any output.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high reset
//   in_valid     upstream request valid
//   in_ready     stage can accept a request this cycle (registered)
//   src_sel      operand source select; 110/111 are illegal
//   b_in         B register value
//   imm_in       raw instruction immediate
//   out_valid    srcb_out holds a valid operand
//   out_ready    ALU consumes the operand this cycle
//   srcb_out     registered operand B
//   out_illegal  illegal-select tag of the entry in the main register
//   err_sticky   set once an illegal select has been accepted
//   clear_err    clears err_sticky; a simultaneous set wins
//   dbg_state    current FSM state (0 EMPTY, 1 ONE, 2 TWO)
//
// DATA_W must be >= IMM_W.
// -----------------------------------------------------------------------------
module alu_srcb_stage #(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int INC_CONST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        src_sel,
  input  logic [DATA_W-1:0] b_in,
  input  logic [IMM_W-1:0]  imm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] srcb_out,
  output logic              out_illegal,
  output logic              err_sticky,
  input  logic              clear_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   main_data_q;
  logic                main_ill_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic                skid_ill_q;
  logic                err_q;

  // ---------------------------------------------------------------------------
  // Operand formation
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] new_data;
  logic              new_ill;

  always_comb begin
    // A size cast of a signed expression extends with the sign bit.
    imm_sext = DATA_W'($signed(imm_in));
    imm_zext = DATA_W'(imm_in);
    new_data = '0;
    new_ill  = 1'b0;
    unique case (src_sel)
      3'b000:  new_data = b_in;
      3'b001:  new_data = DATA_W'(INC_CONST);
      3'b010:  new_data = imm_sext;
      3'b011:  new_data = imm_sext << 2;
      3'b100:  new_data = imm_zext;
      3'b101:  new_data = imm_zext << 16;
      default: begin
        new_data = '0;
        new_ill  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control: next state and register load enables
  // ---------------------------------------------------------------------------
  logic accept;
  logic xfer;
  logic load_main;
  logic main_from_skid;
  logic load_skid;

  assign accept = in_valid && in_ready_q;
  assign xfer   = (state_q != ST_EMPTY) && out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          // Old operand leaves while the new one takes its place.
          load_main = 1'b1;
        end else if (accept) begin
          // ALU stalled: park the new operand in the skid register.
          load_skid = 1'b1;
          state_d   = ST_TWO;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so no accept can happen.
        if (xfer) begin
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // in_ready is the registered complement of "skid full next cycle".
    in_ready_d = (state_d != ST_TWO);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ill_q  <= 1'b0;
      skid_data_q <= '0;
      skid_ill_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;

      if (load_main) begin
        main_data_q <= new_data;
        main_ill_q  <= new_ill;
      end else if (main_from_skid) begin
        main_data_q <= skid_data_q;
        main_ill_q  <= skid_ill_q;
      end

      if (load_skid) begin
        skid_data_q <= new_data;
        skid_ill_q  <= new_ill;
      end else if (main_from_skid) begin
        skid_data_q <= '0;
        skid_ill_q  <= 1'b0;
      end

      // Setting takes priority over clearing.
      if (accept && new_ill) begin
        err_q <= 1'b1;
      end else if (clear_err) begin
        err_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign srcb_out    = main_data_q;
  assign out_illegal = main_ill_q;
  assign err_sticky  = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_srcb_stage.sv
module tb_alu_srcb_stage;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit default instance
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  src_sel;
  logic [31:0] b_in;
  logic [15:0] imm_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] srcb_out;
  logic        out_illegal;
  logic        err_sticky;
  logic        clear_err;
  logic [1:0]  dbg_state;

  // 64-bit instance for the parameter sweep
  logic        w_in_valid;
  logic        w_in_ready;
  logic [2:0]  w_src_sel;
  logic [63:0] w_b_in;
  logic [15:0] w_imm_in;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_srcb_out;
  logic        w_out_illegal;
  logic        w_err_sticky;
  logic        w_clear_err;
  logic [1:0]  w_dbg_state;

  alu_srcb_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .src_sel(src_sel), .b_in(b_in), .imm_in(imm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .srcb_out(srcb_out), .out_illegal(out_illegal),
    .err_sticky(err_sticky), .clear_err(clear_err),
    .dbg_state(dbg_state)
  );

  alu_srcb_stage #(.DATA_W(64), .IMM_W(16), .INC_CONST(8)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .src_sel(w_src_sel), .b_in(w_b_in), .imm_in(w_imm_in),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .srcb_out(w_srcb_out), .out_illegal(w_out_illegal),
    .err_sticky(w_err_sticky), .clear_err(w_clear_err),
    .dbg_state(w_dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------------------
  // Driver helpers: inputs change 1 time unit after the rising edge, and
  // outputs are sampled at that same point, well away from the next edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel,
                       input logic [31:0] b, input logic [15:0] imm);
    in_valid = v;
    src_sel  = sel;
    b_in     = b;
    imm_in   = imm;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 16'h0);
    out_ready   = 1'b1;
    clear_err   = 1'b0;
    w_in_valid  = 1'b0;
    w_src_sel   = 3'b000;
    w_b_in      = 64'h0;
    w_imm_in    = 16'h0;
    w_out_ready = 1'b1;
    w_clear_err = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid",   64'(out_valid),   64'd0);
    chk("rst_srcb_out",    64'(srcb_out),    64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_err_sticky",  64'(err_sticky),  64'd0);
    chk("rst_in_ready",    64'(in_ready),    64'd1);
    chk("rst_state",       64'(dbg_state),   64'd0);

    // Single operand, one-cycle latency
    drive(1'b1, 3'b000, 32'h12345678, 16'h0);
    tick();
    drive(1'b0, 3'b000, 32'h0, 16'h0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data",  64'(srcb_out),  64'h12345678);
    tick();
    chk("single_drain", 64'(out_valid), 64'd0);

    // Back-to-back sources, full throughput
    drive(1'b1, 3'b001, 32'hDEADBEEF, 16'h0);
    tick();
    chk("b2b_inc", 64'(srcb_out), 64'h00000004);
    drive(1'b1, 3'b010, 32'h0, 16'h8000);
    tick();
    chk("b2b_sext", 64'(srcb_out), 64'hFFFF8000);
    drive(1'b1, 3'b011, 32'h0, 16'hFFFF);
    tick();
    chk("b2b_word", 64'(srcb_out), 64'hFFFFFFFC);
    drive(1'b1, 3'b100, 32'h0, 16'h8000);
    tick();
    chk("b2b_zext", 64'(srcb_out), 64'h00008000);
    drive(1'b1, 3'b101, 32'h0, 16'h1234);
    tick();
    chk("b2b_upper", 64'(srcb_out), 64'h12340000);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_legal", 64'(out_illegal), 64'd0);
    drive(1'b0, 3'b000, 32'h0, 16'h0);
    tick();
    chk("b2b_drain", 64'(out_valid), 64'd0);

    // Backpressure through the skid register
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h11, 16'h0);
    tick();
    chk("bp_a_data",  64'(srcb_out), 64'h11);
    chk("bp_a_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 3'b000, 32'h22, 16'h0);
    tick();
    chk("bp_b_ready", 64'(in_ready),  64'd0);
    chk("bp_b_state", 64'(dbg_state), 64'd2);
    chk("bp_b_hold",  64'(srcb_out),  64'h11);
    drive(1'b1, 3'b000, 32'h33, 16'h0);
    tick();
    chk("bp_c_hold",  64'(srcb_out),  64'h11);
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    chk("bp_c_ready", 64'(in_ready),  64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b",     64'(srcb_out), 64'h22);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, 3'b000, 32'h0, 16'h0);
    chk("bp_out_c", 64'(srcb_out),  64'h33);
    chk("bp_c_one", 64'(out_valid), 64'd1);
    tick();
    chk("bp_drain", 64'(out_valid), 64'd0);

    // Illegal selects and the sticky error flag
    drive(1'b1, 3'b110, 32'hFFFFFFFF, 16'hFFFF);
    tick();
    drive(1'b0, 3'b000, 32'h0, 16'h0);
    chk("ill_data",   64'(srcb_out),    64'd0);
    chk("ill_tag",    64'(out_illegal), 64'd1);
    chk("ill_sticky", 64'(err_sticky),  64'd1);
    tick();
    chk("ill_held", 64'(err_sticky), 64'd1);
    clear_err = 1'b1;
    drive(1'b1, 3'b111, 32'h5, 16'h5);
    tick();
    clear_err = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 16'h0);
    chk("ill_set_wins", 64'(err_sticky),  64'd1);
    chk("ill_tag2",     64'(out_illegal), 64'd1);
    tick();
    chk("ill_still_set", 64'(err_sticky), 64'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("ill_cleared", 64'(err_sticky), 64'd0);
    drive(1'b1, 3'b000, 32'hCAFE, 16'h0);
    tick();
    drive(1'b0, 3'b000, 32'h0, 16'h0);
    chk("legal_tag", 64'(out_illegal), 64'd0);
    chk("legal_data", 64'(srcb_out), 64'hCAFE);
    tick();

    // Reset while both entries are occupied
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'hAA, 16'h0);
    tick();
    drive(1'b1, 3'b110, 32'hBB, 16'h0);
    tick();
    drive(1'b0, 3'b000, 32'h0, 16'h0);
    chk("rst2_pre_state",  64'(dbg_state),  64'd2);
    chk("rst2_pre_sticky", 64'(err_sticky), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_valid",  64'(out_valid),  64'd0);
    chk("rst2_ready",  64'(in_ready),   64'd1);
    chk("rst2_data",   64'(srcb_out),   64'd0);
    chk("rst2_sticky", 64'(err_sticky), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst2_no_stale", 64'(out_valid), 64'd0);
    end

    // Parameter sweep: DATA_W=64, INC_CONST=8
    w_in_valid = 1'b1;
    w_src_sel  = 3'b010;
    w_imm_in   = 16'h8001;
    tick();
    chk("w64_sext", w_srcb_out, 64'hFFFFFFFFFFFF8001);
    w_src_sel = 3'b001;
    tick();
    chk("w64_inc", w_srcb_out, 64'h8);
    w_src_sel = 3'b101;
    w_imm_in  = 16'h1234;
    tick();
    w_in_valid = 1'b0;
    chk("w64_upper", w_srcb_out, 64'h0000000012340000);
    tick();
    chk("w64_drain", 64'(w_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
